// File: rtl/booth_multiplier_seq_if.sv
// Purpose : start/done handshake bundle for booth_multiplier_seq (operands in, busy/done/product out).
// Latency : n/a (wires only).
// Backpressure: none; the requester watches busy/done, and start is ignored while an operation runs.
// Ports   : start, multiplier, multiplicand (requester -> unit); busy, done, product (unit -> requester).
interface booth_multiplier_seq_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     multiplier;
  logic [WIDTH-1:0]     multiplicand;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplier, multiplicand,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplier, multiplicand,
    output busy, done, product
  );
endinterface

// File: rtl/booth_multiplier_seq.sv
// Purpose : sequential signed Booth multiplier, one partial-product step per clock; BOOTH_RADIX4_EN selects radix-4.
// Latency : done rises N cycles after the accepting edge (N = WIDTH, or WIDTH/2 radix-4); issue interval N+1.
// Backpressure: start is ignored while running; no queuing; a start seen in DONE begins the next operation at once.
// Ports   : clk, rst_n (async, active-low); bus (slave modport): start, multiplier, multiplicand -> busy, done, product.
module booth_multiplier_seq #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  booth_multiplier_seq_if.slave   bus
);

`ifdef BOOTH_RADIX4_EN
  // Two guard bits: the accumulator must hold +/-2M on top of a running partial sum.
  localparam int UW     = WIDTH + 2;
  localparam int NSTEPS = WIDTH / 2;
`else
  // One guard bit keeps -2^(W-1) * -2^(W-1) from overflowing the upper half.
  localparam int UW     = WIDTH + 1;
  localparam int NSTEPS = WIDTH;
`endif
  localparam int CW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(NSTEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [UW-1:0]        upper_q, upper_d;
  logic [WIDTH-1:0]     lower_q, lower_d;
  logic                 qm1_q, qm1_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // Datapath for one Booth step: recode, add into the upper half, then arithmetic shift.
  logic [UW-1:0]        m_ext;
  logic [UW-1:0]        sum;
  logic [UW-1:0]        upper_sh;
  logic [WIDTH-1:0]     lower_sh;
  logic                 qm1_sh;

  assign m_ext = {{(UW-WIDTH){mcand_q[WIDTH-1]}}, mcand_q};

`ifdef BOOTH_RADIX4_EN
  logic [UW-1:0] m2_ext;
  assign m2_ext = {m_ext[UW-2:0], 1'b0};

  always_comb begin
    sum = upper_q;
    case ({lower_q[1:0], qm1_q})
      3'b001, 3'b010: sum = upper_q + m_ext;
      3'b011:         sum = upper_q + m2_ext;
      3'b100:         sum = upper_q - m2_ext;
      3'b101, 3'b110: sum = upper_q - m_ext;
      default:        sum = upper_q;
    endcase
  end

  assign upper_sh = {{2{sum[UW-1]}}, sum[UW-1:2]};
  assign lower_sh = {sum[1:0], lower_q[WIDTH-1:2]};
  assign qm1_sh   = lower_q[1];
`else
  always_comb begin
    sum = upper_q;
    case ({lower_q[0], qm1_q})
      2'b01:   sum = upper_q + m_ext;
      2'b10:   sum = upper_q - m_ext;
      default: sum = upper_q;
    endcase
  end

  assign upper_sh = {sum[UW-1], sum[UW-1:1]};
  assign lower_sh = {sum[0], lower_q[WIDTH-1:1]};
  assign qm1_sh   = lower_q[0];
`endif

  // Next-state and register updates.
  always_comb begin
    state_d   = state_q;
    upper_d   = upper_q;
    lower_d   = lower_q;
    qm1_d     = qm1_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          upper_d = '0;
          lower_d = bus.multiplier;
          qm1_d   = 1'b0;
          mcand_d = bus.multiplicand;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        upper_d = upper_sh;
        lower_d = lower_sh;
        qm1_d   = qm1_sh;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d   = S_DONE;
          product_d = {upper_sh[WIDTH-1:0], lower_sh};
        end
      end
      S_DONE: begin
        // A start held through DONE is taken on this edge so back-to-back
        // operations run every N+1 cycles.
        state_d = S_IDLE;
        if (bus.start) begin
          state_d = S_RUN;
          upper_d = '0;
          lower_d = bus.multiplier;
          qm1_d   = 1'b0;
          mcand_d = bus.multiplicand;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      upper_q   <= '0;
      lower_q   <= '0;
      qm1_q     <= 1'b0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      upper_q   <= upper_d;
      lower_q   <= lower_d;
      qm1_q     <= qm1_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Purpose : randomized and directed stimulus for booth_multiplier_seq, scored against an integer-multiply reference.
// Latency : expects done exactly N cycles after each accepting edge, issue interval N+1.
// Backpressure: models the unit's acceptance rule to know which start pulses are taken.
module tb_booth_multiplier_seq;
  localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
  localparam int N = W / 2;
`else
  localparam int N = W;
`endif

  logic clk;
  logic rst_n;

  booth_multiplier_seq_if #(.WIDTH(W)) bus ();

  booth_multiplier_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: plain signed multiply at double width.
  function automatic logic [2*W-1:0] ref_mul(logic signed [W-1:0] a, logic signed [W-1:0] b);
    logic signed [2*W-1:0] ae;
    logic signed [2*W-1:0] be;
    ae = a;
    be = b;
    return ae * be;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Acceptance model: a start is taken when no operation is outstanding, or
  // at least N+1 edges after the previous accept.
  logic [2*W-1:0] exp_p[$];
  int  ev;
  int  acc_e;
  bit  act;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev    <= 0;
      acc_e <= 0;
      act   <= 1'b0;
      exp_p.delete();
    end else begin
      ev <= ev + 1;
      if (bus.start && (!act || (ev + 1 - acc_e) >= N + 1)) begin
        act   <= 1'b1;
        acc_e <= ev + 1;
        exp_p.push_back(ref_mul(bus.multiplier, bus.multiplicand));
      end
    end
  end

  // Monitor: compares busy/done/product every cycle; pops the scoreboard on done.
  initial begin : monitor
    logic [2*W-1:0] prod_exp;
    bit busy_exp;
    bit done_exp;
    prod_exp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prod_exp = '0;
        chk("busy in reset", 64'(bus.busy), 64'(0));
        chk("done in reset", 64'(bus.done), 64'(0));
        chk("product in reset", 64'(bus.product), 64'(0));
      end else begin
        busy_exp = act && ((ev - acc_e) <= N);
        done_exp = act && ((ev - acc_e) == N);
        chk("busy", 64'(bus.busy), 64'(busy_exp));
        chk("done timing", 64'(bus.done), 64'(done_exp));
        if (done_exp) begin
          if (exp_p.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: done with no expected result at %0t", $time);
          end else begin
            prod_exp = exp_p.pop_front();
          end
        end
        chk("product", 64'(bus.product), 64'(prod_exp));
      end
    end
  end

  task automatic op(logic [W-1:0] a, logic [W-1:0] b);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplier   = a;
    bus.multiplicand = b;
    @(negedge clk);
    bus.start        = 1'b0;
    bus.multiplier   = W'($urandom());
    bus.multiplicand = W'($urandom());
    repeat (N + 1) @(negedge clk);
  endtask

  int da[12] = '{1, -8, -75, 15, 124, 90, 17, 17, -128, -128, 127, -1};
  int db[12] = '{1, -16, 68, 0, 5, 35, 60, -65, -128, 127, 127, -1};

  initial begin : driver
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.multiplier   = '0;
    bus.multiplicand = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vectors and extremes.
    for (int i = 0; i < 12; i++) op(W'(da[i]), W'(db[i]));

    // Reset mid-run discards the operation and clears the outputs at once.
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplier   = W'(-75);
    bus.multiplicand = W'(68);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("busy after async reset", 64'(bus.busy), 64'(0));
    chk("done after async reset", 64'(bus.done), 64'(0));
    chk("product after async reset", 64'(bus.product), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    op(W'(1), W'(1));

    // Start pulsed while busy with other operands must be ignored.
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplier   = W'(90);
    bus.multiplicand = W'(35);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplier   = W'(-1);
    bus.multiplicand = W'(127);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (N + 2) @(negedge clk);

    // Start held high with operands changing every cycle: back-to-back.
    repeat (4 * (N + 1) + 1) begin
      @(negedge clk);
      bus.start        = 1'b1;
      bus.multiplier   = W'($urandom());
      bus.multiplicand = W'($urandom());
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (N + 2) @(negedge clk);

    // Random operations with random gaps and stray starts.
    repeat (150) begin
      op(W'($urandom()), W'($urandom()));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (N + 3) @(negedge clk);
    chk("scoreboard drained", 64'(exp_p.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
